// File: rtl/regfile_sb.sv
// Multi-read-port register file, r0 hardwired to zero, optional write-first bypass
// and a per-register busy scoreboard for outstanding long-latency writes.
module regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*WIDTH-1:0]    rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    mark_en,
    input  logic [ADDR_W-1:0]       mark_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 has no storage; every access to it is steered away below.
    logic [WIDTH-1:0] mem_q [1:DEPTH-1];
    logic [DEPTH-1:1] busy_q;
    logic [DEPTH-1:1] busy_d;
    logic             wr_hit;
    logic             mark_hit;

    assign wr_hit   = wr_en && (wr_addr != '0);
    assign mark_hit = mark_en && (mark_addr != '0);

    // Mark is applied after the write clear so a same-address mark wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (mark_hit) begin
            busy_d[mark_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            mem_q  <= '{default: '0};
        end else begin
            busy_q <= busy_d;
            if (wr_hit) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            ra = rd_addr[p*ADDR_W +: ADDR_W];
            if (!rst && (ra != '0)) begin
                if ((BYPASS != 0) && wr_hit && (wr_addr == ra)) begin
                    rd_data[p*WIDTH +: WIDTH] = wr_data;
                end else begin
                    rd_data[p*WIDTH +: WIDTH] = mem_q[ra];
                    rd_busy[p]                = busy_q[ra];
                end
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, multi-read-port register file with register 0 hardwired to zero. It adds an optional same-cycle write-to-read bypass and a per-register busy scoreboard for outstanding long-latency writes. It sits in the decode stage of the pipelined CPU: decode reads operands and busy flags, issue marks destinations busy, and writeback writes results and clears busy.

## Interface
Parameters:
- WIDTH, 32, data bits per register
- ADDR_W, 5, address bits; DEPTH = 2**ADDR_W registers
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = write-first (same-cycle write visible on reads); 0 = read-old (reads return stored value)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRD*ADDR_W  read addresses; port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NRD*WIDTH  read data; port p at [p*WIDTH +: WIDTH]
- rd_busy  out  NRD  busy flag of the register addressed by port p
- wr_en  in  1  write enable, active-high (not active-low)
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- mark_en  in  1  set the busy bit of mark_addr (destination issued)
- mark_addr  in  ADDR_W  register to mark busy

## Operation
- Storage: DEPTH x WIDTH registers plus a DEPTH-bit busy vector.
- Register 0 always reads 0 with rd_busy 0. Writes and marks to address 0 are ignored. No storage is required for entry 0.
- Write: when wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0 at the edge.
- Mark: when mark_en=1 and mark_addr!=0, busy[mark_addr] <= 1 at the edge.
- Same address written and marked in one cycle: data is written and busy ends at 1. The mark wins because the new pending op supersedes.
- Different addresses written and marked in one cycle: both take effect independently.
- Reads are combinational, and each port is independent. Any number of ports may address the same register.
- BYPASS=1: if wr_en=1 and wr_addr==rd_addr[p]!=0, then rd_data[p]=wr_data and rd_busy[p]=0 in the same cycle. A concurrent mark to that address does not affect rd_busy until the next cycle.
- BYPASS=0: rd_data[p]=mem[rd_addr[p]] and rd_busy[p]=busy[rd_addr[p]], both pre-edge values.
- Reset: while rst=1, every rd_data is 0 and every rd_busy is 0 (forced combinationally), and wr_en and mark_en are ignored. At the edge with rst=1, all registers clear to 0 and all busy bits clear to 0.
- Reset deasserting mid-sequence: the first cycle after reset sees all zeros and not-busy. Any write or mark presented during the reset cycle is lost.
- Addresses are unsigned and full range; there is no out-of-range case because DEPTH = 2**ADDR_W.

## Timing
- Read latency is 0 cycles (combinational from rd_addr, plus wr_* when BYPASS=1).
- Write-to-read latency:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: 1 cycle (value visible the cycle after the write edge).
- Mark-to-busy latency: rd_busy is visible the cycle after the mark edge.
- Write-to-busy-clear latency: same as write-to-read latency.
- There are no handshakes or backpressure. The stall decision (any rd_busy for a needed operand) is made outside the block.
- Timing path: wr_data and wr_addr to rd_data is combinational when BYPASS=1. The integrator must budget for it.

## Test plan
- Reset: preload r5=32'hDEAD_BEEF with busy set, assert rst one cycle -> rd_data=0 and rd_busy=0 on all ports during rst and after. A write presented with rst=1 leaves r5=0.
- R0 hardwire: write 32'hFFFF_FFFF to r0 and mark r0 -> all ports reading r0 return 0 with rd_busy=0 every cycle.
- Bypass (BYPASS=1): in one cycle, wr r7=32'h1234_5678 while port0 and port1 read r7 -> both show 32'h1234_5678 in that cycle. Repeat with BYPASS=0 -> old value that cycle, new value the next.
- Scoreboard: mark r3 at cycle 0 -> rd_busy=1 from cycle 1. Write r3=32'hA5A5_0000 at cycle 4 -> rd_busy=0 at cycle 4 (BYPASS=1) or at cycle 5 (BYPASS=0), and data matches.
- Simultaneous write+mark: write r9=32'h0000_0042 and mark r9 in the same cycle -> next cycle r9 reads 32'h0000_0042 with rd_busy=1. Write r9 and mark r10 -> r9 not busy, r10 busy.
- Parameter sweep: WIDTH=16/ADDR_W=3/NRD=4 and WIDTH=64/ADDR_W=5/NRD=1 -> random write/mark/read traffic matches a reference model cycle-for-cycle.
